mem_burst_read_engine: RTL
==========================

// Module: mem_burst_read_engine
// PURPOSE
//  Memory-side burst read engine, directly downstream of the frame FIFO read controller.
//  Accepts one burst request (rd_burst_req/len/addr), issues one single-word read command per
//  word to the memory port (valid/ready), keeps up to MAX_OUTSTANDING reads in flight, and
//  returns the data as rd_burst_data_valid/rd_burst_data. Pulses rd_burst_finish when done.
// PARAMETERS
//  MEM_DATA_BITS    32  data word width
//  ADDR_BITS        23  word address width
//  BURST_BITS       10  burst length width
//  MAX_OUTSTANDING  4   max accepted-but-unreturned reads (1..15)
// PORTS
//  mem_clk             in   1              single clock, all logic rising-edge
//  rst_n               in   1              asynchronous, active-low reset
//  rd_burst_req        in   1              burst request; held high by requester until first data valid
//  rd_burst_len        in   BURST_BITS     burst length in words; sampled on accept
//  rd_burst_addr       in   ADDR_BITS      burst base word address; sampled on accept
//  rd_burst_data_valid out  1              one returned word on rd_burst_data this cycle
//  rd_burst_data       out  MEM_DATA_BITS  returned read data
//  rd_burst_finish     out  1              one-cycle pulse: all words of burst returned
//  mem_rd_cmd_valid    out  1              read command valid
//  mem_rd_cmd_ready    in   1              memory accepts command when valid&ready
//  mem_rd_addr         out  ADDR_BITS      command word address
//  mem_rd_data_valid   in   1              memory read data valid (in command order)
//  mem_rd_data         in   MEM_DATA_BITS  memory read data
//  busy                out  1              high in any state except S_IDLE
//  protocol_err        out  1              sticky: mem_rd_data_valid while no read outstanding
// BEHAVIOUR
//  Reset (rst_n=0, async): state=S_IDLE; all outputs 0; counters and latches 0; err cleared.
//  States: S_IDLE, S_ISSUE, S_DRAIN, S_FINISH.
//  S_IDLE: if rd_burst_req: latch addr->cmd_addr, len->len_latch; issued=returned=0;
//   len!=0 -> S_ISSUE, len==0 -> S_FINISH (no commands). Request ignored outside S_IDLE.
//  S_ISSUE: mem_rd_cmd_valid = (issued<len_latch) && (outstanding<MAX_OUTSTANDING), combinational
//   from registers; mem_rd_addr=cmd_addr. Once valid is high, addr stays stable until accepted.
//   On valid&ready: cmd_addr+1 (mod 2^ADDR_BITS, wraps silently), issued+1, outstanding+1.
//   issued reaching len_latch -> S_DRAIN (next cycle).
//  S_DRAIN: no commands; wait until returned==len_latch -> S_FINISH.
//  Data path (all states): mem_rd_data_valid with outstanding>0 -> registered 1-cycle latency
//   to rd_burst_data_valid/rd_burst_data; returned+1, outstanding-1.
//   Accept and return in the same cycle -> outstanding unchanged.
//  Last word may return in S_ISSUE on the accept cycle of the final command; returned==len
//   then wins: go to S_FINISH directly, skipping S_DRAIN.
//  S_FINISH: rd_burst_finish=1 for exactly one cycle, asserted the cycle after the final
//   rd_burst_data_valid (len==0: cycle after accept); -> S_IDLE.
//   A new request is accepted at the earliest in the cycle after S_FINISH.
//  mem_rd_data_valid with outstanding==0: data dropped, protocol_err<=1 (sticky until reset).
//   Includes returns for reads issued before a mid-burst reset.
//  Reset mid-burst: immediate return to S_IDLE, no finish pulse, cmd_valid drops asynchronously.
//  Widths: issued/returned BURST_BITS wide, compared against len_latch.
//   outstanding is clog2(MAX_OUTSTANDING+1) wide, never exceeds MAX_OUTSTANDING.
// TESTING
//  1. addr=0x100,len=4,ready=1,mem latency 3 -> cmds 0x100..0x103; 4 data valids in order;
//     finish 1 cycle after 4th valid; busy low next cycle.
//  2. len=8, latency 10, ready=1 -> never >4 outstanding; cmd_valid drops after 4 accepts;
//     resumes on each return; 8 words total.
//  3. ready toggled pseudo-randomly -> mem_rd_addr stable while valid&!ready;
//     no command lost or duplicated; data matches model.
//  4. addr=0x7FFFFE,len=4 (ADDR_BITS=23) -> cmd addrs 0x7FFFFE,0x7FFFFF,0x000000,0x000001.
//  5. len=0 -> no cmd_valid, finish pulse 1 cycle after accept.
//     Separately: data_valid while idle -> protocol_err=1, no rd_burst_data_valid.
//  6. rst_n low after 2 of 6 words returned, then 2 stale returns after release ->
//     outputs 0 during reset, protocol_err=1, no finish; next len=2 burst completes normally.

Source files
------------

// File: rtl/mem_burst_read_engine.sv
// Burst read engine: turns one burst request into a stream of single-word
// memory read commands. It keeps a bounded number of reads in flight and
// forwards the returned words with one cycle of registered latency.
module mem_burst_read_engine #(
  parameter int MEM_DATA_BITS   = 32,
  parameter int ADDR_BITS       = 23,
  parameter int BURST_BITS      = 10,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     mem_clk,
  input  logic                     rst_n,
  input  logic                     rd_burst_req,
  input  logic [BURST_BITS-1:0]    rd_burst_len,
  input  logic [ADDR_BITS-1:0]     rd_burst_addr,
  output logic                     rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0] rd_burst_data,
  output logic                     rd_burst_finish,
  output logic                     mem_rd_cmd_valid,
  input  logic                     mem_rd_cmd_ready,
  output logic [ADDR_BITS-1:0]     mem_rd_addr,
  input  logic                     mem_rd_data_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_rd_data,
  output logic                     busy,
  output logic                     protocol_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_e;

  localparam int                    OUT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0]      OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0]      OUT_ONE   = OUT_W'(1);
  localparam logic [BURST_BITS-1:0] BURST_ONE = BURST_BITS'(1);
  localparam logic [ADDR_BITS-1:0]  ADDR_ONE  = ADDR_BITS'(1);

  state_e                   state_q, state_d;
  logic [ADDR_BITS-1:0]     cmd_addr_q, cmd_addr_d;
  logic [BURST_BITS-1:0]    len_q, len_d;
  logic [BURST_BITS-1:0]    issued_q, issued_d;
  logic [BURST_BITS-1:0]    returned_q, returned_d;
  logic [OUT_W-1:0]         outstanding_q, outstanding_d;
  logic                     rdata_valid_q, rdata_valid_d;
  logic [MEM_DATA_BITS-1:0] rdata_q, rdata_d;
  logic                     err_q, err_d;

  logic accept;    // burst request taken this cycle
  logic cmd_fire;  // read command handshake this cycle
  logic ret;       // legitimate read return this cycle

  assign accept   = (state_q == S_IDLE) && rd_burst_req;
  assign cmd_fire = mem_rd_cmd_valid && mem_rd_cmd_ready;
  assign ret      = mem_rd_data_valid && (outstanding_q != '0);

  assign mem_rd_addr         = cmd_addr_q;
  assign rd_burst_data_valid = rdata_valid_q;
  assign rd_burst_data       = rdata_q;
  assign protocol_err        = err_q;

  // State register.
  // NOTE: clocked blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a completed return count wins over entering drain.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (rd_burst_req) state_d = (rd_burst_len == '0) ? S_FINISH : S_ISSUE;
      end
      S_ISSUE: begin
        if (returned_q == len_q)    state_d = S_FINISH;
        else if (issued_q == len_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (returned_q == len_q) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and registered counters only.
  always_comb begin
    mem_rd_cmd_valid = (state_q == S_ISSUE) && (issued_q < len_q) && (outstanding_q < OUT_MAX);
    rd_burst_finish  = (state_q == S_FINISH);
    busy             = (state_q != S_IDLE);
  end

  // Burst bookkeeping, in-flight count, return path and sticky error.
  always_comb begin
    cmd_addr_d    = cmd_addr_q;
    len_d         = len_q;
    issued_d      = issued_q;
    returned_d    = returned_q;
    outstanding_d = outstanding_q;
    err_d         = err_q | (mem_rd_data_valid && (outstanding_q == '0));
    rdata_valid_d = ret;
    rdata_d       = ret ? mem_rd_data : rdata_q;
    if (accept) begin
      cmd_addr_d = rd_burst_addr;
      len_d      = rd_burst_len;
      issued_d   = '0;
      returned_d = '0;
    end
    if (cmd_fire) begin
      cmd_addr_d = cmd_addr_q + ADDR_ONE;  // wraps modulo the address space
      issued_d   = issued_q + BURST_ONE;
    end
    if (ret) returned_d = returned_q + BURST_ONE;
    unique case ({cmd_fire, ret})
      2'b10:   outstanding_d = outstanding_q + OUT_ONE;
      2'b01:   outstanding_d = outstanding_q - OUT_ONE;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Datapath registers; all cleared so a mid-burst reset leaves nothing in flight.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_addr_q    <= '0;
      len_q         <= '0;
      issued_q      <= '0;
      returned_q    <= '0;
      outstanding_q <= '0;
      rdata_valid_q <= 1'b0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      cmd_addr_q    <= cmd_addr_d;
      len_q         <= len_d;
      issued_q      <= issued_d;
      returned_q    <= returned_d;
      outstanding_q <= outstanding_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
    end
  end

endmodule
